dmem_responder: RTL and testbench

Data-memory responder for the RV32I core's data port: the memory-side end of the dmem_req/dmem_ready handshake. It holds a word-organised SRAM array and answers each request after a configurable number of wait states, with one ready pulse per transfer. It shifts store data into byte lanes and right-aligns load data, so the core's byte and halfword loads and stores work unmodified. Out-of-range accesses are reported on dmem_err. It instantiates once next to the core in the SoC top.

---
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core's dmem_req/dmem_ready handshake.
// Word-organised SRAM with programmable wait states. Stores are shifted into
// byte lanes, and loads are right-aligned by the byte offset. Out-of-range
// accesses complete with dmem_err=1.
// Optional build macro: DMEM_MISALIGN_CHECK_EN rejects store byte enables that
// do not form a naturally placed byte, halfword or word.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_mode,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [3:0]  dmem_be,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_err
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_commit;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_err;

  logic          w_req;
  logic [31:0]   w_offset;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_wdata_sh;
  logic [31:0]   w_rdata_sh;
  logic          w_be_bad;
  logic          w_err;
  logic          w_wr;

  // Scan mode masks the request so test shifting never touches the array.
  assign w_req      = dmem_req & ~scan_mode;
  // Unsigned subtraction wraps, so addresses below BASE_ADDR land far out of range.
  assign w_offset   = dmem_addr - BASE_ADDR;
  assign w_in_range = (w_offset < LIMIT);
  assign w_idx      = w_offset[AW+1:2];
  assign w_lane     = dmem_addr[1:0];
  assign w_wdata_sh = dmem_wdata << {w_lane, 3'b000};
  assign w_rdata_sh = r_mem[w_idx] >> {w_lane, 3'b000};

`ifdef DMEM_MISALIGN_CHECK_EN
  logic       w_be_legal;
  logic [1:0] w_be_low;
  // Accept only natural byte/half/word enable patterns whose lowest lane matches the address.
  always_comb begin
    w_be_legal = 1'b0;
    w_be_low   = 2'd0;
    case (dmem_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_be_legal = 1'b1;
      default:                   w_be_legal = 1'b0;
    endcase
    casez (dmem_be)
      4'b???1: w_be_low = 2'd0;
      4'b??10: w_be_low = 2'd1;
      4'b?100: w_be_low = 2'd2;
      4'b1000: w_be_low = 2'd3;
      default: w_be_low = 2'd0;
    endcase
    w_be_bad = !w_be_legal || (w_be_low != w_lane);
  end
`else
  assign w_be_bad = 1'b0;
`endif

  assign w_err = !w_in_range || (dmem_we && w_be_bad);
  assign w_wr  = w_commit && dmem_we && !w_err;

  // State and wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: the commit strobe marks the edge that performs the access.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_commit    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_cnt_nxt   = WS_M1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte-lane store into the array; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  // Response registers: loaded at the commit edge, cleared on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else if (w_commit) begin
      r_ready <= 1'b1;
      r_err   <= w_err;
      r_rdata <= (!dmem_we && !w_err) ? w_rdata_sh : 32'd0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end
  end

  assign dmem_ready = r_ready;
  assign dmem_err   = r_err;
  assign dmem_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) over a
// 16-word array, driven by directed and random transfers. Expected responses
// come from a byte-addressed memory model and flow through per-instance queues
// to a monitor that checks data, error flag and response cycle.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          NB   = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic              clk;
  logic [1:0]        rst_n, scan, req, we, rdy, err;
  logic [1:0][3:0]   be;
  logic [1:0][31:0]  addr, wdata, rdata;

  int   cyc = 0;
  int   vecs = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit [7:0] mb [2][NB];

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .scan_mode(scan[0]), .dmem_req(req[0]),
    .dmem_we(we[0]), .dmem_be(be[0]), .dmem_addr(addr[0]), .dmem_wdata(wdata[0]),
    .dmem_rdata(rdata[0]), .dmem_ready(rdy[0]), .dmem_err(err[0]));

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .scan_mode(scan[1]), .dmem_req(req[1]),
    .dmem_we(we[1]), .dmem_be(be[1]), .dmem_addr(addr[1]), .dmem_wdata(wdata[1]),
    .dmem_rdata(rdata[1]), .dmem_ready(rdy[1]), .dmem_err(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Reference behaviour: byte memory, applied in request order.
  function automatic exp_t model(input int k, input bit w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] off, sh, word;
    int          wb, lane;
    bit          bad;
    off  = a - BASE;
    bad  = 1'b0;
    lane = int'(a % 4);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (w) begin
      bad = !(b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
      if (!bad) begin
        for (int i = 3; i >= 0; i--) if (b[i]) wb = i;
        bad = (wb != lane);
      end
    end
`endif
    e.err   = (off >= NB) || (w && bad);
    e.rdata = 32'd0;
    e.cyc   = 0;
    if (!e.err) begin
      wb = int'(off) - lane;
      if (w) begin
        sh = d << (8 * lane);
        for (int i = 0; i < 4; i++) if (b[i]) mb[k][wb+i] = sh[8*i +: 8];
      end else begin
        word    = {mb[k][wb+3], mb[k][wb+2], mb[k][wb+1], mb[k][wb]};
        e.rdata = word >> (8 * lane);
      end
    end
    return e;
  endfunction

  // Issue one transfer (called just after a rising edge) and wait for its ready.
  task automatic issue(input int k, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, input bit hold);
    exp_t e;
    int   n;
    e     = model(k, w, b, a, d);
    e.cyc = cyc + 1 + ws(k);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d; req[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy[k] !== 1'b1 && n < 40);
    if (rdy[k] !== 1'b1) begin
      fails++;
      vecs++;
      $display("FAIL timeout inst%0d addr=%h: no ready within %0d cycles", k, a, n);
    end
    @(posedge clk);
    #1;
    if (!hold) req[k] = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle, a ready must match the queue head; otherwise outputs idle at 0.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      vecs++;
      if (rdy[k] === 1'b1) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          fails++;
          $display("FAIL unexpected_ready inst%0d cyc=%0d rdata=%h err=%b", k, cyc, rdata[k], err[k]);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          if (rdata[k] !== e.rdata || err[k] !== e.err || cyc != e.cyc) begin
            fails++;
            $display("FAIL resp inst%0d: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                     k, rdata[k], err[k], cyc, e.rdata, e.err, e.cyc);
          end
        end
      end else if (rdy[k] !== 1'b0 || rdata[k] !== 32'd0 || err[k] !== 1'b0) begin
        fails++;
        $display("FAIL idle_outputs inst%0d cyc=%0d: ready=%b rdata=%h err=%b, want 0/0/0",
                 k, cyc, rdy[k], rdata[k], err[k]);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  b;
    bit          w;
    int          lane, sz;
    rst_n = 2'b00; scan = 2'b00; req = 2'b00; we = 2'b00;
    be = '0; addr = '0; wdata = '0;
    tick(3);
    rst_n = 2'b11;
    tick(1);

    // Fill both arrays so every later load has a defined expectation.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        issue(k, 1'b1, 4'b1111, BASE + 32'(4 * i), $urandom, 1'b0);

    // Zero-wait directed sequence: word store/load, byte store, aligned loads.
    issue(0, 1'b1, 4'b1111, 32'h1000_0010, 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b0, 4'b0000, 32'h1000_0010, 32'h0, 1'b0);
    issue(0, 1'b1, 4'b1000, 32'h1000_0013, 32'h0000_0055, 1'b0);
    issue(0, 1'b0, 4'b0000, 32'h1000_0010, 32'h0, 1'b0);
    issue(0, 1'b0, 4'b0000, 32'h1000_0013, 32'h0, 1'b0);
    issue(0, 1'b1, 4'b1000, 32'h1000_0003, 32'h0000_00A7, 1'b0);
    issue(0, 1'b0, 4'b0000, 32'h1000_0000, 32'h0, 1'b0);
    issue(0, 1'b1, 4'b0000, 32'h1000_0004, 32'hFFFF_FFFF, 1'b0);
    issue(0, 1'b0, 4'b0000, 32'h1000_0004, 32'h0, 1'b0);
    // Out-of-range store and load, then in-range load for corruption.
    issue(0, 1'b1, 4'b1111, BASE + 32'd64, 32'h1234_5678, 1'b0);
    issue(0, 1'b0, 4'b0000, 32'h0FFF_FFFC, 32'h0, 1'b0);
    issue(0, 1'b0, 4'b0000, 32'h1000_003C, 32'h0, 1'b0);
    // Back-to-back held requests at zero wait.
    issue(0, 1'b0, 4'b0000, 32'h1000_0010, 32'h0, 1'b1);
    issue(0, 1'b0, 4'b0000, 32'h1000_0012, 32'h0, 1'b0);

    // Three-wait sequence, including back-to-back held requests.
    issue(1, 1'b1, 4'b1111, 32'h1000_0020, 32'hCAFE_F00D, 1'b1);
    issue(1, 1'b0, 4'b0000, 32'h1000_0020, 32'h0, 1'b1);
    issue(1, 1'b0, 4'b0000, 32'h1000_0021, 32'h0, 1'b0);

    // Request dropped during the wait: no response, no write.
    we[1] = 1'b1; be[1] = 4'b1111; addr[1] = 32'h1000_0020; wdata[1] = 32'h0BAD_0BAD;
    req[1] = 1'b1;
    tick(2);
    req[1] = 1'b0;
    tick(6);
    issue(1, 1'b0, 4'b0000, 32'h1000_0020, 32'h0, 1'b0);

    // Asynchronous reset while a store waits: outputs clear at once, store discarded.
    we[1] = 1'b1; be[1] = 4'b1111; addr[1] = 32'h1000_0024; wdata[1] = 32'h5A5A_5A5A;
    req[1] = 1'b1;
    tick(3);
    rst_n[1] = 1'b0;
    #1;
    vecs++;
    if (rdy[1] !== 1'b0 || rdata[1] !== 32'd0 || err[1] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_wait: ready=%b rdata=%h err=%b, want 0/0/0", rdy[1], rdata[1], err[1]);
    end
    req[1] = 1'b0;
    tick(2);
    rst_n[1] = 1'b1;
    tick(1);
    issue(1, 1'b0, 4'b0000, 32'h1000_0024, 32'h0, 1'b0);

    // Scan mode masks a held request: the monitor flags any ready.
    scan[1] = 1'b1;
    we[1] = 1'b1; be[1] = 4'b1111; addr[1] = 32'h1000_0028; wdata[1] = 32'h7777_7777;
    req[1] = 1'b1;
    tick(12);
    req[1] = 1'b0;
    tick(1);
    scan[1] = 1'b0;
    issue(1, 1'b0, 4'b0000, 32'h1000_0028, 32'h0, 1'b0);

    // Random mixed traffic, with occasional back-to-back requests.
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 80; t++) begin
        a    = BASE - 32'd8 + 32'($urandom_range(0, 79));
        w    = 1'($urandom_range(0, 1));
        sz   = $urandom_range(0, 3);
        d    = $urandom;
        lane = int'(a % 4);
        case (sz)
          0: begin a = a & ~32'd3; b = 4'b1111; end
          1: begin a = a & ~32'd1; b = 4'(4'b0011 << (a % 4)); end
          2: b = 4'(4'b0001 << lane);
          default: b = 4'($urandom_range(0, 15));
        endcase
        issue(k, w, w ? b : 4'b0000, a, d, (t != 79) && ($urandom_range(0, 3) == 0));
      end
    end

    tick(8);
    vecs++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL pending: %0d/%0d responses outstanding, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
